ubuff_unpack_x8: RTL

- Read-side counterpart of the 8-lane packing buffer: consumes dense 512-bit lines of eight 64-bit words with an MSB-first contiguous valid mask.
- Serialises each line onto a narrower OUT_LANES-wide stream for per-lane downstream consumers.
- Ready/valid handshake on both sides.
- Line-end (last) marker is propagated to the final output beat of its line.

---
 rtl/ubuff_pkg.sv | 31 +++
 rtl/ubuff_lane_sel.sv | 28 ++
 rtl/ubuff_unpack_x8.sv | 89 ++++++++
 3 files changed

// File: rtl/ubuff_pkg.sv
// Shared constants, state type and mask helper for the 8-lane unpack buffer.
package ubuff_pkg;

  localparam int unsigned WORD_W   = 64;
  localparam int unsigned IN_LANES = 8;

  typedef enum logic {StEmpty, StDrain} state_e;

  typedef struct packed {
    logic [3:0] cnt;
    logic       err;
  } lead_t;

  // Leading ones counted from the MSB; err flags any one below the first zero.
  function automatic lead_t lead_ones(input logic [IN_LANES-1:0] mask);
    lead_t r;
    logic  seen_zero;
    r         = '0;
    seen_zero = 1'b0;
    for (int i = IN_LANES - 1; i >= 0; i--) begin
      if (!seen_zero) begin
        if (mask[i]) r.cnt = r.cnt + 4'd1;
        else         seen_zero = 1'b1;
      end else if (mask[i]) begin
        r.err = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ubuff_lane_sel.sv
// Picks OUT_LANES consecutive words starting at a lane pointer (lane 7 first),
// zero-filling any slice at or beyond the valid count.
module ubuff_lane_sel
  import ubuff_pkg::*;
#(
  parameter int unsigned OUT_LANES = 2
) (
  input  logic [WORD_W*IN_LANES-1:0]  line,
  input  logic [3:0]                  ptr,
  input  logic [3:0]                  cnt,
  output logic [WORD_W*OUT_LANES-1:0] word_out,
  output logic [OUT_LANES-1:0]        valid_out
);

  // Output slice OUT_LANES-1-j carries lane 7-(ptr+j); top slice is earliest.
  always_comb begin
    word_out  = '0;
    valid_out = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      if ((int'(ptr) + j) < int'(cnt)) begin
        valid_out[OUT_LANES-1-j] = 1'b1;
        word_out[(OUT_LANES-1-j)*WORD_W +: WORD_W] =
          line[(IN_LANES-1-(int'(ptr)+j))*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/ubuff_unpack_x8.sv
// Serialises dense 8-word lines into OUT_LANES-wide beats with ready/valid on
// both sides; a zero-count line yields a single empty beat (flush marker).
module ubuff_unpack_x8
  import ubuff_pkg::*;
#(
  parameter int unsigned OUT_LANES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WORD_W*IN_LANES-1:0]  word_in,
  input  logic [IN_LANES-1:0]         word_in_valid,
  input  logic                        in_valid,
  input  logic                        last_input_in,
  output logic                        in_ready,
  output logic [WORD_W*OUT_LANES-1:0] word_out,
  output logic [OUT_LANES-1:0]        valid_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        last_out,
  output logic                        mask_err
);

  state_e                     state_q;
  logic [WORD_W*IN_LANES-1:0] line_q;
  logic [3:0]                 cnt_q;
  logic [3:0]                 ptr_q;
  logic                       last_q;
  logic                       err_q;

  logic                        draining;
  logic                        final_beat;
  logic                        accept;
  lead_t                       lead;
  logic [WORD_W*OUT_LANES-1:0] sel_word;
  logic [OUT_LANES-1:0]        sel_valid;

  assign lead     = lead_ones(word_in_valid);
  assign draining = (state_q == StDrain);
  // Final when this beat covers everything up to cnt; cnt=0 is final at once.
  assign final_beat = draining &&
                      (({1'b0, ptr_q} + 5'(OUT_LANES)) >= {1'b0, cnt_q});
  assign in_ready  = !rst && ((state_q == StEmpty) || (final_beat && out_ready));
  assign accept    = in_valid && in_ready;

  ubuff_lane_sel #(
    .OUT_LANES (OUT_LANES)
  ) u_lane_sel (
    .line      (line_q),
    .ptr       (ptr_q),
    .cnt       (cnt_q),
    .word_out  (sel_word),
    .valid_out (sel_valid)
  );

  // Beat outputs are pure functions of held state, so they hold under stall.
  always_comb begin
    out_valid = draining;
    word_out  = draining ? sel_word : '0;
    valid_out = draining ? sel_valid : '0;
    last_out  = final_beat && last_q;
    mask_err  = err_q;
  end

  // Line capture, pointer advance and drain/empty sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      line_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && lead.err;
      if (accept) begin
        // Also covers the no-bubble case: final beat retires as the next loads.
        state_q <= StDrain;
        line_q  <= word_in;
        cnt_q   <= lead.cnt;
        last_q  <= last_input_in;
        ptr_q   <= '0;
      end else if (draining && out_ready) begin
        if (final_beat) state_q <= StEmpty;
        else            ptr_q   <= ptr_q + 4'(OUT_LANES);
      end
    end
  end

endmodule
